// File: rtl/pts_pkg.sv
// Purpose : shared types and helpers for the par_to_valid_stream unloader.
// Latency : n/a (types and constant functions only).
// Backpr. : n/a.
// Contents: state_t (IDLE/SEND) and pts_cnt_w(), the width of the word
//           count and index registers.
package pts_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Bits needed to hold any value 0..depth inclusive.
    function automatic int pts_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pts_down_counter.sv
// Purpose : loadable down-counter with zero flag; holds the remaining word count.
// Latency : load/decrement visible one cycle after the enabling edge.
// Backpr. : none; it decrements only when dec_en is asserted.
// Ports   : clk/rst (async active-high), load_en/load_val (load has priority),
//           dec_en (saturates at zero), cnt (current value), zero (cnt == 0).
module pts_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_en) begin
            cnt_d = load_val;
        end else if (dec_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/par_to_valid_stream.sv
// Purpose : unloads one parallel burst of up to depth words as a ready/valid word stream, tagging the final word with out_last.
// Latency : load accepted at edge N shows word 0 in cycle N+1; k words finish at edge N+k with out_rdy held high.
// Backpr. : out_rdy low freezes out_data/out_last and all state; load_rdy is low while a burst is being sent.
// Ports   : clk, rst (async active-high); load_vld/load_rdy/load_data/load_count
//           (burst in, word i at [i*width +: width], count clamped to depth);
//           out_vld/out_rdy/out_data/out_last (word stream out).
// Option  : PAR_TO_VALID_STREAM_BACK_TO_BACK_EN lets the next burst load on the
//           same edge the last word leaves, giving gapless back-to-back bursts.
module par_to_valid_stream
    import pts_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_vld,
    output logic                       load_rdy,
    input  logic [width*depth-1:0]     load_data,
    input  logic [$clog2(depth+1)-1:0] load_count,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [width-1:0]           out_data,
    output logic                       out_last
);

    localparam int            CW      = pts_cnt_w(depth);
    localparam logic [CW-1:0] DEPTH_C = CW'(depth);

    state_t                   state_q, state_d;
    logic [width*depth-1:0]   words_q, words_d;
    logic [CW-1:0]            idx_q, idx_d;

    logic [CW-1:0]            rem;
    logic                     rem_zero;
    logic [CW-1:0]            count_clamped;
    logic                     count_nz;
    logic                     load_fire;
    logic                     out_fire;
    logic                     last_fire;
    logic [width-1:0]         word_sel;

    // Oversized counts simply mean "the whole array".
    assign count_clamped = (load_count > DEPTH_C) ? DEPTH_C : load_count;
    assign count_nz      = (count_clamped != '0);
    assign load_fire     = load_vld && load_rdy;
    assign out_fire      = out_vld && out_rdy;
    assign last_fire     = out_fire && out_last;

    // Load has priority over decrement, which matters only when a new burst
    // is accepted on the same edge as the previous burst's final word.
    pts_down_counter #(
        .W (CW)
    ) u_remaining (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_fire),
        .load_val (count_clamped),
        .dec_en   (out_fire),
        .cnt      (rem),
        .zero     (rem_zero)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A zero-count burst is accepted but produces nothing.
                if (load_fire && count_nz) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rem_zero) begin
                    // Cannot normally be reached; recover rather than stream garbage.
                    state_d = IDLE;
                end else if (last_fire) begin
                    state_d = (load_fire && count_nz) ? SEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_rdy = 1'b0;
        out_vld  = 1'b0;
        out_last = 1'b0;
        out_data = '0;
        case (state_q)
            IDLE: begin
                load_rdy = 1'b1;
            end
            SEND: begin
                out_vld  = 1'b1;
                out_last = (rem == CW'(1));
                out_data = word_sel;
`ifdef PAR_TO_VALID_STREAM_BACK_TO_BACK_EN
                load_rdy = out_last && out_rdy;
`endif
            end
            default: begin
                load_rdy = 1'b0;
            end
        endcase
    end

    // ---------------- datapath: word array and index ----------------
    always_comb begin
        words_d = load_fire ? load_data : words_q;
        idx_d   = idx_q;
        if (load_fire || last_fire) begin
            // Index restarts on every new burst and never steps past count-1.
            idx_d = '0;
        end else if (out_fire) begin
            idx_d = idx_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_q <= '0;
            idx_q   <= '0;
        end else begin
            words_q <= words_d;
            idx_q   <= idx_d;
        end
    end

    // Output word mux; comparing against each slot keeps the index width free
    // of the array's power-of-two addressing.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < depth; i++) begin
            if (idx_q == CW'(i)) begin
                word_sel = words_q[i*width +: width];
            end
        end
    end

endmodule

// File: tb/tb_par_to_valid_stream.sv
module tb_par_to_valid_stream;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           load_vld = 1'b0;
    logic           load_rdy;
    logic [W*D-1:0] load_data = '0;
    logic [CW-1:0]  load_count = '0;
    logic           out_vld;
    logic           out_rdy = 1'b1;
    logic [W-1:0]   out_data;
    logic           out_last;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    typedef struct {
        int          cnt;
        logic [63:0] data;
        int          mode;
        int          n_words;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;
    int   rdy_mode = 0;
    int   rdy_cyc  = 0;

    always #5 clk = ~clk;

    par_to_valid_stream #(
        .width (W),
        .depth (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_vld   (load_vld),
        .load_rdy   (load_rdy),
        .load_data  (load_data),
        .load_count (load_count),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // out_rdy driver: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        rdy_cyc++;
        case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ((rdy_cyc % 3) == 0);
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: every valid cycle must match the head of the queue, which
    // also proves the word holds stable through stall cycles.
    always @(negedge clk) begin
        if (!rst && out_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_vld", 64'(out_vld), 64'(0));
            end else begin
                check("out_data", 64'(out_data), 64'(exp_q[0].d));
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
                if (out_rdy) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic push_words(input logic [W*D-1:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d    = data[i*W +: W];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_load(input int cnt, input logic [W*D-1:0] data, input int n_exp);
        int t;
        t          = 0;
        load_data  = data;
        load_count = CW'(cnt);
        load_vld   = 1'b1;
        push_words(data, n_exp);
        do begin
            @(negedge clk);
            t++;
        end while (!load_rdy && t < 200);
        check("load_accept", 64'(load_rdy), 64'(1));
        @(posedge clk);
        #1;
        load_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || out_vld) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
        check({name, "_load_rdy"}, 64'(load_rdy), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[7];
        int         pop0;
        int         nacc;
        logic       acc;
        logic [6:0] hist;
        logic [6:0] hist_exp;

        vecs[0] = '{4,  64'h0000_0000_4433_2211, 0, 4};
        vecs[1] = '{4,  64'h0000_0000_4433_2211, 1, 4};
        vecs[2] = '{0,  64'h0000_0000_DEAD_BEEF, 0, 0};
        vecs[3] = '{15, 64'hF0E1_D2C3_B4A5_9687, 0, 8};
        vecs[4] = '{1,  64'h0000_0000_0000_005A, 1, 1};
        vecs[5] = '{8,  64'h0123_4567_89AB_CDEF, 2, 8};
        vecs[6] = '{3,  64'h0000_0000_00CC_BBAA, 2, 3};

        // Reset values.
        #2;
        check("rst_out_vld", 64'(out_vld), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 64'(load_rdy), 64'(1));

        // Table of bursts.
        for (int i = 0; i < 7; i++) begin
            rdy_mode = vecs[i].mode;
            pop0     = n_pop;
            do_load(vecs[i].cnt, vecs[i].data, vecs[i].n_words);
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_words", i), 64'(n_pop - pop0), 64'(vecs[i].n_words));
        end

        // Load request during SEND (not on the last word) is ignored.
        rdy_mode = 0;
        pop0     = n_pop;
        do_load(4, 64'h0000_0000_0D0C_0B0A, 4);
        load_vld   = 1'b1;
        load_count = CW'(3);
        load_data  = 64'h0000_0000_00EE_EEEE;
        #2;
        check("rdy_in_send", 64'(load_rdy), 64'(0));
        @(posedge clk);
        #1;
        load_vld = 1'b0;
        drain("ignore");
        check("ignore_words", 64'(n_pop - pop0), 64'(4));

        // Reset after two words of an 8-word burst.
        do_load(8, 64'h8877_6655_4433_2211, 8);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_vld", 64'(out_vld), 64'(0));
        check("midrst_out_last", 64'(out_last), 64'(0));
        check("midrst_words_sent", 64'(exp_q.size()), 64'(6));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pop0 = n_pop;
        do_load(3, 64'h0000_0000_0033_3231, 3);
        drain("after_rst");
        check("after_rst_words", 64'(n_pop - pop0), 64'(3));

        // load_vld held high across two 2-word bursts.
        hist       = '0;
        nacc       = 0;
        load_vld   = 1'b1;
        load_count = CW'(2);
        load_data  = 64'h0000_0000_0000_A2A1;
        push_words(64'h0000_0000_0000_A2A1, 2);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            hist[c] = out_vld;
            acc     = load_vld && load_rdy;
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    load_data = 64'h0000_0000_0000_B2B1;
                    push_words(64'h0000_0000_0000_B2B1, 2);
                end else begin
                    load_vld = 1'b0;
                end
            end
        end
        load_vld = 1'b0;
`ifdef PAR_TO_VALID_STREAM_BACK_TO_BACK_EN
        hist_exp = 7'b0011110;
`else
        hist_exp = 7'b0110110;
`endif
        check("b2b_vld_pattern", 64'(hist), 64'(hist_exp));
        check("b2b_loads", 64'(nacc), 64'(2));
        drain("b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
